// File: rtl/dfd_trace_funnel.sv
// Purpose: merges the even and odd DFD trace channels into one show-ahead sink stream and sequences network flushes.
// Latency: a beat written into an empty channel FIFO is presented on the sink one cycle later.
// Backpressure: sink_rdy low holds the head beat; Bp outputs are advisory, and a beat hitting a full FIFO is dropped and flagged.

// Generic show-ahead FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module dfd_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  output logic                     push_ok_o,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_dat_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign full       = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_pop     = pop_i & ~empty_o;
  assign do_push    = push_i & (~full | do_pop);
  assign push_ok_o  = do_push;
  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // Storage array carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

module dfd_trace_funnel #(
  parameter  int NUM_CORES           = 8,
  parameter  int DATA_WIDTH_IN_BYTES = 16,
  parameter  int FIFO_DEPTH          = 8,
  parameter  int BP_SLACK            = 4,
  parameter  int FLUSH_HOLD          = 8,
  localparam int NUM_CORES_IN_PATH   = NUM_CORES / 2,
  localparam int DATA_WIDTH          = 8 * DATA_WIDTH_IN_BYTES
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_CORES_IN_PATH-1:0]  TN_TR_Even_Vld,
  input  logic                          TN_TR_Even_Src,
  input  logic [DATA_WIDTH-1:0]         TN_TR_Even_Data,
  input  logic [NUM_CORES_IN_PATH-1:0]  TN_TR_Odd_Vld,
  input  logic                          TN_TR_Odd_Src,
  input  logic [DATA_WIDTH-1:0]         TN_TR_Odd_Data,
  output logic                          TN_TR_Ntrace_Bp,
  output logic                          TN_TR_Dst_Bp,
  output logic                          TN_TR_Ntrace_Flush,
  output logic                          TN_TR_Dst_Flush,
  output logic [NUM_CORES-1:0]          TN_TR_Enabled_Srcs,
  input  logic [NUM_CORES-1:0]          cfg_enabled_srcs,
  input  logic                          cfg_ntrace_flush_req,
  input  logic                          cfg_dst_flush_req,
  input  logic                          cfg_err_clr,
  output logic                          flush_done,
  output logic                          sink_vld,
  input  logic                          sink_rdy,
  output logic                          sink_src,
  output logic [$clog2(NUM_CORES)-1:0]  sink_core_id,
  output logic [DATA_WIDTH-1:0]         sink_data,
  output logic                          err_multi_vld,
  output logic                          err_overflow
);
  localparam int HOP_W  = (NUM_CORES_IN_PATH > 1) ? $clog2(NUM_CORES_IN_PATH) : 1;
  localparam int CID_W  = $clog2(NUM_CORES);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int HOLD_W = $clog2(FLUSH_HOLD) + 1;
  localparam logic [CW-1:0] TH_NTRACE = CW'(FIFO_DEPTH - BP_SLACK);
  localparam logic [CW-1:0] TH_DST    = CW'(FIFO_DEPTH - BP_SLACK - 2);

  typedef struct packed {
    logic             src;
    logic [HOP_W-1:0] hop;
    logic [DATA_WIDTH-1:0] dat;
  } beat_t;

  typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_DRAIN, ST_DONE} fl_state_e;

  // Index of the lowest set bit; a malformed multi-hot valid still stores a single hop.
  function automatic logic [HOP_W-1:0] low_idx(input logic [NUM_CORES_IN_PATH-1:0] v);
    logic [HOP_W-1:0] r;
    r = '0;
    for (int i = NUM_CORES_IN_PATH - 1; i >= 0; i--) begin
      if (v[i]) r = HOP_W'(i);
    end
    return r;
  endfunction

  // Channel 0 is even, channel 1 is odd.
  logic [NUM_CORES_IN_PATH-1:0] ch_vld [2];
  logic                         ch_src [2];
  logic [DATA_WIDTH-1:0]        ch_dat [2];
  beat_t                        wr_beat [2];
  beat_t                        head_beat [2];
  logic [CW-1:0]                cnt [2];
  logic [1:0]                   push;
  logic [1:0]                   push_ok;
  logic [1:0]                   pop;
  logic [1:0]                   empty;
  logic [1:0]                   multi;

  assign ch_vld[0] = TN_TR_Even_Vld;
  assign ch_vld[1] = TN_TR_Odd_Vld;
  assign ch_src[0] = TN_TR_Even_Src;
  assign ch_src[1] = TN_TR_Odd_Src;
  assign ch_dat[0] = TN_TR_Even_Data;
  assign ch_dat[1] = TN_TR_Odd_Data;

  for (genvar c = 0; c < 2; c++) begin : g_ch
    assign push[c]    = |ch_vld[c];
    assign multi[c]   = |(ch_vld[c] & (ch_vld[c] - 1'b1));
    assign wr_beat[c] = '{src: ch_src[c], hop: low_idx(ch_vld[c]), dat: ch_dat[c]};

    dfd_trace_fifo #(
      .WIDTH ($bits(beat_t)),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push_i     (push[c]),
      .push_dat_i (wr_beat[c]),
      .push_ok_o  (push_ok[c]),
      .pop_i      (pop[c]),
      .head_dat_o (head_beat[c]),
      .empty_o    (empty[c]),
      .count_o    (cnt[c])
    );
  end

  // Arbitration state: last popped channel (1 = odd) and a lock that pins the grant during a stall.
  logic rr_last_q;
  logic lock_vld_q;
  logic lock_ch_q;
  logic gnt;
  beat_t sink_beat;

  // Grant selection: a held stall keeps its channel, otherwise round-robin between non-empty channels.
  always_comb begin
    gnt = 1'b0;
    if (lock_vld_q)                 gnt = lock_ch_q;
    else if (!empty[0] && !empty[1]) gnt = ~rr_last_q;
    else if (!empty[1])             gnt = 1'b1;
  end

  assign sink_beat    = head_beat[gnt];
  assign sink_vld     = ~empty[gnt];
  assign sink_src     = sink_vld & sink_beat.src;
  assign sink_core_id = sink_vld ? CID_W'({sink_beat.hop, gnt}) : '0;
  assign sink_data    = sink_vld ? sink_beat.dat : '0;
  assign pop[0]       = sink_vld & sink_rdy & ~gnt;
  assign pop[1]       = sink_vld & sink_rdy & gnt;

  // Round-robin pointer and stall lock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_last_q  <= 1'b1;
      lock_vld_q <= 1'b0;
      lock_ch_q  <= 1'b0;
    end else begin
      if (sink_vld && sink_rdy) rr_last_q <= gnt;
      lock_vld_q <= sink_vld & ~sink_rdy;
      lock_ch_q  <= gnt;
    end
  end

  // Error flags: a set in the same cycle as a clear wins.
  logic multi_set;
  logic ovf_set;
  logic err_multi_q, err_multi_d;
  logic err_ovf_q, err_ovf_d;

  assign multi_set   = (push[0] & multi[0]) | (push[1] & multi[1]);
  assign ovf_set     = (push[0] & ~push_ok[0]) | (push[1] & ~push_ok[1]);
  assign err_multi_d = multi_set | (err_multi_q & ~cfg_err_clr);
  assign err_ovf_d   = ovf_set | (err_ovf_q & ~cfg_err_clr);

  // Registered status toward the network: backpressure hints, source enables, sticky errors.
  logic bp_ntrace_q;
  logic bp_dst_q;
  logic [NUM_CORES-1:0] en_srcs_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bp_ntrace_q <= 1'b0;
      bp_dst_q    <= 1'b0;
      en_srcs_q   <= '0;
      err_multi_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      bp_ntrace_q <= (cnt[0] >= TH_NTRACE) | (cnt[1] >= TH_NTRACE);
      bp_dst_q    <= (cnt[0] >= TH_DST) | (cnt[1] >= TH_DST);
      en_srcs_q   <= cfg_enabled_srcs;
      err_multi_q <= err_multi_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign TN_TR_Ntrace_Bp    = bp_ntrace_q;
  assign TN_TR_Dst_Bp       = bp_dst_q;
  assign TN_TR_Enabled_Srcs = en_srcs_q;
  assign err_multi_vld      = err_multi_q;
  assign err_overflow       = err_ovf_q;

  // Flush sequencer state.
  fl_state_e         state_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              ntr_flush_q;
  logic              dst_flush_q;
  logic              flush_done_q;
  logic              drain_idle;

  assign drain_idle = (&empty) & ~(|TN_TR_Even_Vld) & ~(|TN_TR_Odd_Vld);

  // Flush FSM: hold the requested flush lines, wait for the funnel to drain, then pulse done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      hold_cnt_q   <= '0;
      ntr_flush_q  <= 1'b0;
      dst_flush_q  <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_ntrace_flush_req || cfg_dst_flush_req) begin
            state_q     <= ST_FLUSH;
            ntr_flush_q <= cfg_ntrace_flush_req;
            dst_flush_q <= cfg_dst_flush_req;
            hold_cnt_q  <= '0;
          end
        end
        ST_FLUSH: begin
          if (hold_cnt_q == HOLD_W'(FLUSH_HOLD - 1)) begin
            state_q     <= ST_DRAIN;
            ntr_flush_q <= 1'b0;
            dst_flush_q <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_idle) begin
            state_q      <= ST_DONE;
            flush_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q      <= ST_IDLE;
          flush_done_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign TN_TR_Ntrace_Flush = ntr_flush_q;
  assign TN_TR_Dst_Flush    = dst_flush_q;
  assign flush_done         = flush_done_q;
endmodule

// File: tb/tb_dfd_trace_funnel.sv
// Directed bench for dfd_trace_funnel with default parameters (8 cores, 128-bit data, depth 8).
// Inputs change and outputs are sampled on the falling clock edge.
// Each scenario task checks its own expected values.
module tb_dfd_trace_funnel;
  logic         clk;
  logic         reset_n;
  logic [3:0]   even_vld, odd_vld;
  logic         even_src, odd_src;
  logic [127:0] even_data, odd_data;
  logic         ntr_bp, dst_bp, ntr_flush, dst_flush;
  logic [7:0]   en_srcs;
  logic [7:0]   cfg_enabled_srcs;
  logic         cfg_ntrace_flush_req, cfg_dst_flush_req, cfg_err_clr;
  logic         flush_done;
  logic         sink_vld, sink_rdy, sink_src;
  logic [2:0]   sink_core_id;
  logic [127:0] sink_data;
  logic         err_multi_vld, err_overflow;

  int checks = 0;
  int errors = 0;

  dfd_trace_funnel dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .TN_TR_Even_Vld       (even_vld),
    .TN_TR_Even_Src       (even_src),
    .TN_TR_Even_Data      (even_data),
    .TN_TR_Odd_Vld        (odd_vld),
    .TN_TR_Odd_Src        (odd_src),
    .TN_TR_Odd_Data       (odd_data),
    .TN_TR_Ntrace_Bp      (ntr_bp),
    .TN_TR_Dst_Bp         (dst_bp),
    .TN_TR_Ntrace_Flush   (ntr_flush),
    .TN_TR_Dst_Flush      (dst_flush),
    .TN_TR_Enabled_Srcs   (en_srcs),
    .cfg_enabled_srcs     (cfg_enabled_srcs),
    .cfg_ntrace_flush_req (cfg_ntrace_flush_req),
    .cfg_dst_flush_req    (cfg_dst_flush_req),
    .cfg_err_clr          (cfg_err_clr),
    .flush_done           (flush_done),
    .sink_vld             (sink_vld),
    .sink_rdy             (sink_rdy),
    .sink_src             (sink_src),
    .sink_core_id         (sink_core_id),
    .sink_data            (sink_data),
    .err_multi_vld        (err_multi_vld),
    .err_overflow         (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    even_vld = '0; odd_vld = '0; even_src = 0; odd_src = 0;
    even_data = '0; odd_data = '0;
    cfg_ntrace_flush_req = 0; cfg_dst_flush_req = 0; cfg_err_clr = 0;
    sink_rdy = 0;
  endtask

  // Ends on a falling edge with reset released for one full cycle.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 0;
    clear_inputs();
    cfg_enabled_srcs = 8'hA5;
    #3;
    checks++;
    if ({sink_vld, sink_src, sink_core_id, ntr_bp, dst_bp, ntr_flush, dst_flush,
         flush_done, err_multi_vld, err_overflow, en_srcs} !== '0 || sink_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs vld=%0b id=%0d bp=%0b%0b fl=%0b%0b done=%0b err=%0b%0b en=%h data=%h expected all zero",
               sink_vld, sink_core_id, ntr_bp, dst_bp, ntr_flush, dst_flush, flush_done,
               err_multi_vld, err_overflow, en_srcs, sink_data);
    end
    @(negedge clk);
    checks++;
    if (en_srcs !== 8'h00) begin
      errors++; $display("FAIL reset_enables_held en=%h expected 00", en_srcs);
    end
    reset_n = 1;
    @(negedge clk);
    checks++;
    if (en_srcs !== 8'hA5) begin
      errors++; $display("FAIL enables_delay en=%h expected a5", en_srcs);
    end
    cfg_enabled_srcs = 8'h3C;
    checks++;
    if (en_srcs !== 8'hA5) begin
      errors++; $display("FAIL enables_not_combinational en=%h expected a5", en_srcs);
    end
    @(negedge clk);
    checks++;
    if (en_srcs !== 8'h3C) begin
      errors++; $display("FAIL enables_update en=%h expected 3c", en_srcs);
    end
  endtask

  task automatic test_single();
    logic [127:0] a;
    a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    do_reset();
    sink_rdy = 1;
    even_vld = 4'b0010; even_src = 1; even_data = a;
    @(negedge clk);
    even_vld = '0; even_src = 0;
    checks++;
    if (sink_vld !== 1'b1 || sink_core_id !== 3'd2 || sink_src !== 1'b1 || sink_data !== a) begin
      errors++;
      $display("FAIL single_beat vld=%0b id=%0d src=%0b data=%h expected 1 2 1 %h",
               sink_vld, sink_core_id, sink_src, sink_data, a);
    end
    @(negedge clk);
    checks++;
    if (sink_vld !== 1'b0) begin
      errors++; $display("FAIL single_pop vld=%0b expected 0", sink_vld);
    end
  endtask

  task automatic test_rr();
    int b, ch, idx;
    logic [127:0] exp_d;
    do_reset();
    sink_rdy = 1;
    for (int k = 0; k < 10; k++) begin
      if (k >= 1 && k <= 8) begin
        b = k - 1; ch = b % 2; idx = b / 2;
        exp_d = (ch == 1 ? 128'h2000 : 128'h1000) + 128'(idx);
        checks++;
        if (sink_vld !== 1'b1 || sink_core_id !== 3'(2 * idx + ch) || sink_src !== 1'(ch) || sink_data !== exp_d) begin
          errors++;
          $display("FAIL rr_beat%0d vld=%0b id=%0d src=%0b data=%h expected 1 %0d %0d %h",
                   b, sink_vld, sink_core_id, sink_src, sink_data, 2 * idx + ch, ch, exp_d);
        end
      end
      if (k == 9) begin
        checks++;
        if (sink_vld !== 1'b0 || err_overflow !== 1'b0) begin
          errors++; $display("FAIL rr_end vld=%0b ovf=%0b expected 0 0", sink_vld, err_overflow);
        end
      end
      if (k < 4) begin
        even_vld = 4'b0001 << k; odd_vld = 4'b0001 << k;
        even_src = 0; odd_src = 1;
        even_data = 128'h1000 + 128'(k); odd_data = 128'h2000 + 128'(k);
      end else begin
        even_vld = '0; odd_vld = '0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_overflow();
    int j;
    do_reset();
    sink_rdy = 0;
    for (int k = 0; k < 9; k++) begin
      even_vld = 4'b0001; even_src = 0; even_data = 128'hA0 + 128'(k);
      @(negedge clk);
      j = k + 1;
      checks++;
      if (dst_bp !== (j >= 3) || ntr_bp !== (j >= 5) || err_overflow !== (j >= 9)) begin
        errors++;
        $display("FAIL ovf_bp_write%0d dst=%0b ntr=%0b ovf=%0b expected %0b %0b %0b",
                 j, dst_bp, ntr_bp, err_overflow, j >= 3, j >= 5, j >= 9);
      end
    end
    even_vld = '0;
    checks++;
    if (sink_vld !== 1'b1 || sink_core_id !== 3'd0 || sink_data !== 128'hA0) begin
      errors++;
      $display("FAIL ovf_stall_head vld=%0b id=%0d data=%h expected 1 0 a0", sink_vld, sink_core_id, sink_data);
    end
    sink_rdy = 1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sink_vld !== 1'b1 || sink_data !== 128'hA0 + 128'(i)) begin
        errors++;
        $display("FAIL ovf_drain%0d vld=%0b data=%h expected 1 %h", i, sink_vld, sink_data, 128'hA0 + 128'(i));
      end
      @(negedge clk);
    end
    checks++;
    if (sink_vld !== 1'b0 || err_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_dropped vld=%0b ovf=%0b expected 0 1", sink_vld, err_overflow);
    end
    cfg_err_clr = 1;
    @(negedge clk);
    cfg_err_clr = 0;
    checks++;
    if (err_overflow !== 1'b0 || dst_bp !== 1'b0 || ntr_bp !== 1'b0) begin
      errors++; $display("FAIL ovf_clear ovf=%0b dst=%0b ntr=%0b expected 0 0 0", err_overflow, dst_bp, ntr_bp);
    end
  endtask

  task automatic test_multi();
    do_reset();
    sink_rdy = 0;
    odd_vld = 4'b0101; odd_src = 1; odd_data = 128'h55;
    @(negedge clk);
    odd_vld = '0;
    checks++;
    if (err_multi_vld !== 1'b1 || sink_vld !== 1'b1 || sink_core_id !== 3'd1 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL multi_set err=%0b vld=%0b id=%0d ovf=%0b expected 1 1 1 0",
               err_multi_vld, sink_vld, sink_core_id, err_overflow);
    end
    cfg_err_clr = 1;
    @(negedge clk);
    cfg_err_clr = 0;
    checks++;
    if (err_multi_vld !== 1'b0) begin
      errors++; $display("FAIL multi_clear err=%0b expected 0", err_multi_vld);
    end
    odd_vld = 4'b0110; odd_data = 128'h66; cfg_err_clr = 1;
    @(negedge clk);
    odd_vld = '0; cfg_err_clr = 0;
    checks++;
    if (err_multi_vld !== 1'b1) begin
      errors++; $display("FAIL multi_set_beats_clear err=%0b expected 1", err_multi_vld);
    end
    sink_rdy = 1;
    checks++;
    if (sink_core_id !== 3'd1 || sink_data !== 128'h55) begin
      errors++; $display("FAIL multi_beat0 id=%0d data=%h expected 1 55", sink_core_id, sink_data);
    end
    @(negedge clk);
    checks++;
    if (sink_vld !== 1'b1 || sink_core_id !== 3'd3 || sink_data !== 128'h66) begin
      errors++; $display("FAIL multi_beat1 vld=%0b id=%0d data=%h expected 1 3 66", sink_vld, sink_core_id, sink_data);
    end
  endtask

  task automatic test_stall();
    do_reset();
    sink_rdy = 1;
    even_vld = 4'b0001; even_data = 128'hE0;
    @(negedge clk);
    even_vld = '0;
    @(negedge clk);
    checks++;
    if (sink_vld !== 1'b0) begin
      errors++; $display("FAIL stall_prepop vld=%0b expected 0", sink_vld);
    end
    sink_rdy = 0;
    even_vld = 4'b0100; even_data = 128'hE1;
    @(negedge clk);
    even_vld = '0;
    odd_vld = 4'b0001; odd_src = 1; odd_data = 128'hD1;
    @(negedge clk);
    odd_vld = '0;
    checks++;
    if (sink_vld !== 1'b1 || sink_core_id !== 3'd4 || sink_data !== 128'hE1) begin
      errors++;
      $display("FAIL stall_hold id=%0d data=%h expected 4 e1", sink_core_id, sink_data);
    end
    sink_rdy = 1;
    @(negedge clk);
    checks++;
    if (sink_vld !== 1'b1 || sink_core_id !== 3'd1 || sink_src !== 1'b1 || sink_data !== 128'hD1) begin
      errors++;
      $display("FAIL stall_next id=%0d src=%0b data=%h expected 1 1 d1", sink_core_id, sink_src, sink_data);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    int ntr_n, dst_hi, done_n, first, last, done_at;
    do_reset();
    sink_rdy = 0;
    for (int k = 0; k < 3; k++) begin
      even_vld = 4'b0001; even_data = 128'(k);
      @(negedge clk);
    end
    even_vld = '0;
    cfg_ntrace_flush_req = 1;
    ntr_n = 0; dst_hi = 0; done_n = 0; first = -1; last = -1; done_at = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      cfg_ntrace_flush_req = 0;
      cfg_dst_flush_req = (i == 3);
      if (i == 10) sink_rdy = 1;
      if (ntr_flush === 1'b1) begin
        ntr_n++;
        if (first < 0) first = i;
        last = i;
      end
      if (dst_flush !== 1'b0) dst_hi++;
      if (flush_done === 1'b1) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
    end
    checks++;
    if (ntr_n != 8 || first != 1 || last != 8) begin
      errors++; $display("FAIL flush_hold cycles=%0d first=%0d last=%0d expected 8 1 8", ntr_n, first, last);
    end
    checks++;
    if (dst_hi != 0) begin
      errors++; $display("FAIL flush_dst_quiet cycles=%0d expected 0", dst_hi);
    end
    checks++;
    if (done_n != 1 || done_at != 14) begin
      errors++; $display("FAIL flush_done pulses=%0d at=%0d expected 1 14", done_n, done_at);
    end
  endtask

  task automatic test_reset_flush();
    int bad;
    do_reset();
    sink_rdy = 0;
    even_vld = 4'b0001; even_data = 128'h77;
    @(negedge clk);
    @(negedge clk);
    even_vld = '0;
    cfg_dst_flush_req = 1;
    @(negedge clk);
    cfg_dst_flush_req = 0;
    @(negedge clk);
    checks++;
    if (dst_flush !== 1'b1 || dst_bp !== 1'b1 || sink_vld !== 1'b1) begin
      errors++; $display("FAIL rstfl_pre dst_flush=%0b dst_bp=%0b vld=%0b expected 1 1 1", dst_flush, dst_bp, sink_vld);
    end
    #2;
    reset_n = 0;
    #1;
    checks++;
    if (dst_flush !== 1'b0 || ntr_flush !== 1'b0 || dst_bp !== 1'b0 || sink_vld !== 1'b0) begin
      errors++;
      $display("FAIL rstfl_async dst_flush=%0b ntr_flush=%0b dst_bp=%0b vld=%0b expected 0 0 0 0",
               dst_flush, ntr_flush, dst_bp, sink_vld);
    end
    @(negedge clk);
    reset_n = 1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (flush_done !== 1'b0 || dst_flush !== 1'b0 || ntr_flush !== 1'b0 || sink_vld !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rstfl_after cycles_with_activity=%0d expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_overflow();
    test_multi();
    test_stall();
    test_flush();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
